// File: rtl/wb_master_arb.sv
// Two-master Wishbone arbiter: round-robin or fixed-priority grant per bus cycle,
// with a stalled-strobe watchdog that terminates a hung transfer with err.
module wb_master_arb #(
   parameter int DW       = 16,
   parameter int AW       = 32,
   parameter int SW       = 2,
   parameter int PRIORITY = 0,
   parameter int TIMEOUT  = 255
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   input  logic [SW-1:0] m0_sel_i,
   input  logic          m0_we_i,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   input  logic [SW-1:0] m1_sel_i,
   input  logic          m1_we_i,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   output logic [SW-1:0] s_sel_o,
   output logic          s_we_o,
   output logic          s_cyc_o,
   output logic          s_stb_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack_i,
   output logic [1:0]    gnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT0  = 2'd1,
      ST_GNT1  = 2'd2,
      ST_ABORT = 2'd3
   } state_t;

   localparam logic       PRIO_FIXED = (PRIORITY != 0);
   localparam logic       TO_EN      = (TIMEOUT != 0);
   localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

   state_t     state_r;
   state_t     state_nxt_s;
   logic       last_r;
   logic       abort_m_r;
   logic       err0_r;
   logic       err1_r;
   logic [7:0] wait_cnt_r;
   logic       stall_s;
   logic       timeout_s;

   // last == 1 means master 1 was served most recently, so master 0 wins a tie.
   function automatic state_t arbitrate(input logic c0, input logic c1, input logic last);
      state_t res;
      res = ST_IDLE;
      if (c0 && c1) begin
         if (PRIO_FIXED || !last) begin
            res = ST_GNT1;
         end else begin
            res = ST_GNT0;
         end
      end else if (c0) begin
         res = ST_GNT0;
      end else if (c1) begin
         res = ST_GNT1;
      end else begin
         res = ST_IDLE;
      end
      return res;
   endfunction

   assign stall_s   = s_stb_o && !s_ack_i;
   assign timeout_s = TO_EN && stall_s && (wait_cnt_r == TO_LAST);

   // Next-state selection: arbitration, release/handover and watchdog abort.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            state_nxt_s = arbitrate(m0_cyc_i, m1_cyc_i, last_r);
         end
         ST_GNT0: begin
            if (!m0_cyc_i) begin
               state_nxt_s = m1_cyc_i ? ST_GNT1 : ST_IDLE;
            end else if (timeout_s) begin
               state_nxt_s = ST_ABORT;
            end else begin
               state_nxt_s = ST_GNT0;
            end
         end
         ST_GNT1: begin
            if (!m1_cyc_i) begin
               state_nxt_s = m0_cyc_i ? ST_GNT0 : ST_IDLE;
            end else if (timeout_s) begin
               state_nxt_s = ST_ABORT;
            end else begin
               state_nxt_s = ST_GNT1;
            end
         end
         ST_ABORT: begin
            if (abort_m_r ? !m1_cyc_i : !m0_cyc_i) begin
               state_nxt_s = arbitrate(m0_cyc_i, m1_cyc_i, last_r);
            end else begin
               state_nxt_s = ST_ABORT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Bus muxes; everything toward the slave is zero when no grant is held.
   always_comb begin
      s_adr_o  = {AW{1'b0}};
      s_dat_o  = {DW{1'b0}};
      s_sel_o  = {SW{1'b0}};
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      gnt_o    = 2'b00;
      case (state_r)
         ST_GNT0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            m0_ack_o = s_ack_i;
            gnt_o    = 2'b01;
         end
         ST_GNT1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            m1_ack_o = s_ack_i;
            gnt_o    = 2'b10;
         end
         default: begin
            gnt_o = 2'b00;
         end
      endcase
   end

   assign m0_dat_o = s_dat_i;
   assign m1_dat_o = s_dat_i;
   assign m0_err_o = err0_r;
   assign m1_err_o = err1_r;

   // State register plus round-robin history, updated on grant entry.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_r <= ST_IDLE;
         last_r  <= 1'b1;
      end else begin
         state_r <= state_nxt_s;
         if (state_nxt_s == ST_GNT0 && state_r != ST_GNT0) begin
            last_r <= 1'b0;
         end else if (state_nxt_s == ST_GNT1 && state_r != ST_GNT1) begin
            last_r <= 1'b1;
         end else begin
            last_r <= last_r;
         end
      end
   end

   // Watchdog: remember which master was aborted and raise its one-cycle err.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         abort_m_r <= 1'b0;
         err0_r    <= 1'b0;
         err1_r    <= 1'b0;
      end else begin
         err0_r <= (state_r == ST_GNT0) && (state_nxt_s == ST_ABORT);
         err1_r <= (state_r == ST_GNT1) && (state_nxt_s == ST_ABORT);
         if (state_nxt_s == ST_ABORT && state_r != ST_ABORT) begin
            abort_m_r <= (state_r == ST_GNT1);
         end else begin
            abort_m_r <= abort_m_r;
         end
      end
   end

   // Stalled-strobe counter; any grant change restarts it.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         wait_cnt_r <= 8'd0;
      end else if (state_nxt_s != state_r) begin
         wait_cnt_r <= 8'd0;
      end else if (stall_s) begin
         wait_cnt_r <= wait_cnt_r + 8'd1;
      end else begin
         wait_cnt_r <= 8'd0;
      end
   end

endmodule
